mem_port_arbiter: RTL and testbench

- Shares the single 16-bit memory port between instruction fetch (read-only, word) and the memory stage (read/write, word or byte).
- Sequences each access with a req/ack handshake and a memory-side ready, and returns raw words to the requesters.
- The pipeline derives its stage enables from the ack outputs; the memory stage still does big-endian byte-lane selection on returned data.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch port, the data port and the memory port of the
// single-port memory arbiter.
//   slave  : arbiter view (takes requests and read data, drives acks,
//            returned words and the memory strobes/address/data).
//   master : requester/memory view (the opposite directions).
interface mem_port_arbiter_if;
  // fetch port
  logic        if_req_i;
  logic [15:0] if_addr_i;
  logic        if_ack_o;
  logic [15:0] if_rdata_o;
  // data port
  logic        dm_req_i;
  logic        dm_we_i;
  logic        dm_word_i;
  logic [15:0] dm_addr_i;
  logic [15:0] dm_wdata_i;
  logic        dm_ack_o;
  logic [15:0] dm_rdata_o;
  // memory port
  logic [15:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_data_o;
  logic [15:0] mem_data_i;
  logic        mem_ready_i;

  modport slave (
    input  if_req_i, if_addr_i,
    input  dm_req_i, dm_we_i, dm_word_i, dm_addr_i, dm_wdata_i,
    input  mem_data_i, mem_ready_i,
    output if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
    output mem_addr_o, mem_re_o, mem_we_o, mem_be_o, mem_data_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output dm_req_i, dm_we_i, dm_word_i, dm_addr_i, dm_wdata_i,
    output mem_data_i, mem_ready_i,
    input  if_ack_o, if_rdata_o, dm_ack_o, dm_rdata_o,
    input  mem_addr_o, mem_re_o, mem_we_o, mem_be_o, mem_data_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 16-bit memory port between instruction fetch (word reads) and
// the memory stage (word/byte reads and writes). Each access is granted
// from IDLE, held on the registered memory outputs until mem_ready_i, then
// acknowledged with a one-cycle pulse carrying the raw word read.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.slave (fetch, data and memory ports)
// Parameter:
//   MAX_STREAK : data grants allowed while fetch waits before fetch is
//                forced; 0 gives strict data priority.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; grant on an eligible request
// BUSY_IF | fetch read on the memory port, waiting for mem_ready_i
// BUSY_DM | data read/write on the memory port, waiting for mem_ready_i
module mem_port_arbiter #(
  parameter int MAX_STREAK = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t      state, state_nxt;
  logic [SW-1:0] streak;
  logic        if_ack_q, dm_ack_q;
  logic [15:0] if_rdata_q, dm_rdata_q;
  logic [15:0] mem_addr_q, mem_data_q;
  logic        mem_re_q, mem_we_q;
  logic [1:0]  mem_be_q;

  logic        if_elig, dm_elig, force_if;
  logic        grant_if, grant_dm, done_if, done_dm;

  // A requester is masked during its own ack cycle: its req is still the
  // one that was just completed.
  assign if_elig  = bus.if_req_i & ~if_ack_q;
  assign dm_elig  = bus.dm_req_i & ~dm_ack_q;
  assign force_if = (MAX_STREAK > 0) && (streak == STREAK_MAX);

  always_comb begin
    state_nxt = state;
    grant_if  = 1'b0;
    grant_dm  = 1'b0;
    done_if   = 1'b0;
    done_dm   = 1'b0;
    case (state)
      IDLE: begin
        if (if_elig && (!dm_elig || force_if)) begin
          grant_if  = 1'b1;
          state_nxt = BUSY_IF;
        end else if (dm_elig) begin
          grant_dm  = 1'b1;
          state_nxt = BUSY_DM;
        end
      end
      BUSY_IF: begin
        if (bus.mem_ready_i) begin
          done_if   = 1'b1;
          state_nxt = IDLE;
        end
      end
      BUSY_DM: begin
        if (bus.mem_ready_i) begin
          done_dm   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      streak     <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_be_q   <= 2'b00;
    end else begin
      state    <= state_nxt;
      if_ack_q <= done_if;
      dm_ack_q <= done_dm;

      if (grant_if) begin
        mem_addr_q <= bus.if_addr_i;
        mem_re_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_be_q   <= 2'b11;
        streak     <= '0;
      end else if (grant_dm) begin
        mem_addr_q <= bus.dm_addr_i;
        mem_data_q <= bus.dm_wdata_i;
        mem_re_q   <= ~bus.dm_we_i;
        mem_we_q   <= bus.dm_we_i;
        // big-endian lanes: even address is the MSB byte
        if (bus.dm_word_i)
          mem_be_q <= 2'b11;
        else
          mem_be_q <= bus.dm_addr_i[0] ? 2'b01 : 2'b10;
        if (bus.if_req_i && (streak != STREAK_MAX))
          streak <= streak + SW'(1);
      end

      if (done_if) begin
        if_rdata_q <= bus.mem_data_i;
        mem_re_q   <= 1'b0;
        mem_we_q   <= 1'b0;
      end
      if (done_dm) begin
        if (!mem_we_q)
          dm_rdata_q <= bus.mem_data_i;
        mem_re_q   <= 1'b0;
        mem_we_q   <= 1'b0;
      end
    end
  end

  assign bus.if_ack_o   = if_ack_q;
  assign bus.if_rdata_o = if_rdata_q;
  assign bus.dm_ack_o   = dm_ack_q;
  assign bus.dm_rdata_o = dm_rdata_q;
  assign bus.mem_addr_o = mem_addr_q;
  assign bus.mem_re_o   = mem_re_q;
  assign bus.mem_we_o   = mem_we_q;
  assign bus.mem_be_o   = mem_be_q;
  assign bus.mem_data_o = mem_data_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_STREAK = 4). Inputs change and
// outputs are sampled 1 ns after each rising edge.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  logic [15:0] last_dm;

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.MAX_STREAK(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 16'h0000;
    bus.dm_req_i    = 1'b0;
    bus.dm_we_i     = 1'b0;
    bus.dm_word_i   = 1'b1;
    bus.dm_addr_i   = 16'h0000;
    bus.dm_wdata_i  = 16'h0000;
    bus.mem_data_i  = 16'h0000;
    bus.mem_ready_i = 1'b0;
    repeat (2) step();

    // reset state
    chk("rst_re",    bus.mem_re_o,   0);
    chk("rst_we",    bus.mem_we_o,   0);
    chk("rst_be",    bus.mem_be_o,   0);
    chk("rst_addr",  bus.mem_addr_o, 0);
    chk("rst_acks",  {bus.if_ack_o, bus.dm_ack_o}, 0);
    chk("rst_rdata", {bus.if_rdata_o, bus.dm_rdata_o}, 0);
    rst_n = 1'b1;
    step();

    // fetch only, minimum latency
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0100;
    step();
    chk("f_re",    bus.mem_re_o,   1);
    chk("f_we",    bus.mem_we_o,   0);
    chk("f_be",    bus.mem_be_o,   2'b11);
    chk("f_addr",  bus.mem_addr_o, 16'h0100);
    chk("f_noack", bus.if_ack_o,   0);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'hBEEF;
    step();
    chk("f_ack",   bus.if_ack_o,   1);
    chk("f_rdata", bus.if_rdata_o, 16'hBEEF);
    chk("f_redrop", bus.mem_re_o,  0);
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();
    chk("f_ackpulse", bus.if_ack_o,  0);
    chk("f_hold",     bus.if_rdata_o, 16'hBEEF);

    // simultaneous requests: data first, fetch on the data ack cycle
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0200;
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_word_i = 1'b1;
    bus.dm_addr_i = 16'h2000;
    step();
    chk("s_daddr", bus.mem_addr_o, 16'h2000);
    chk("s_dre",   bus.mem_re_o,   1);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'h1234;
    step();
    chk("s_dack",  bus.dm_ack_o,   1);
    chk("s_drd",   bus.dm_rdata_o, 16'h1234);
    last_dm = 16'h1234;
    bus.dm_req_i   = 1'b0;
    bus.mem_data_i = 16'h5678;
    step();
    chk("s_fnogap", bus.mem_addr_o, 16'h0200);
    chk("s_fre",    bus.mem_re_o,   1);
    chk("s_dackpl", bus.dm_ack_o,   0);
    step();
    chk("s_fack",  bus.if_ack_o,   1);
    chk("s_frd",   bus.if_rdata_o, 16'h5678);
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // streak: four data grants with fetch waiting, then fetch is forced
    bus.dm_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus.dm_addr_i = 16'h3000 + 16'(k);
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = 16'h0300;
      step();
      chk($sformatf("st_d%0d", k), bus.mem_addr_o, 16'h3000 + k);
      bus.mem_ready_i = 1'b1;
      bus.mem_data_i  = 16'h3300 + 16'(k);
      step();
      chk($sformatf("st_dack%0d", k), bus.dm_ack_o, 1);
      last_dm = 16'h3300 + 16'(k);
      // fetch steps away over the data ack cycle so nothing is granted
      bus.if_req_i    = 1'b0;
      bus.mem_ready_i = 1'b0;
      step();
    end
    bus.dm_addr_i = 16'h3100;
    bus.if_req_i  = 1'b1;
    step();
    chk("st_force", bus.mem_addr_o, 16'h0300);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'h4444;
    step();
    chk("st_fack", bus.if_ack_o, 1);
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();
    chk("st_dafter", bus.mem_addr_o, 16'h3100);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'h3131;
    step();
    last_dm = 16'h3131;
    bus.mem_ready_i = 1'b0;
    step();
    // streak was cleared by the fetch grant, so data wins again
    bus.dm_addr_i = 16'h3200;
    bus.if_req_i  = 1'b1;
    step();
    chk("st_reset", bus.mem_addr_o, 16'h3200);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'h3232;
    step();
    last_dm = 16'h3232;
    bus.dm_req_i    = 1'b0;
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // byte write at odd address
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_word_i  = 1'b0;
    bus.dm_addr_i  = 16'h0011;
    bus.dm_wdata_i = 16'h00A5;
    step();
    chk("bw_we",   bus.mem_we_o,   1);
    chk("bw_re",   bus.mem_re_o,   0);
    chk("bw_be",   bus.mem_be_o,   2'b01);
    chk("bw_data", bus.mem_data_o, 16'h00A5);
    chk("bw_addr", bus.mem_addr_o, 16'h0011);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'hFFFF;
    step();
    chk("bw_ack",   bus.dm_ack_o,   1);
    chk("bw_rdkeep", bus.dm_rdata_o, last_dm);
    chk("bw_wedrop", bus.mem_we_o,  0);
    bus.dm_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    // byte read at even address with a five-cycle memory stall
    bus.dm_req_i  = 1'b1;
    bus.dm_we_i   = 1'b0;
    bus.dm_word_i = 1'b0;
    bus.dm_addr_i = 16'h0010;
    step();
    chk("br_be", bus.mem_be_o, 2'b10);
    chk("br_re", bus.mem_re_o, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("stall_out%0d", k),
          {bus.mem_addr_o, bus.mem_be_o, bus.mem_re_o, bus.mem_we_o},
          {16'h0010, 2'b10, 1'b1, 1'b0});
      chk($sformatf("stall_noack%0d", k), bus.dm_ack_o, 0);
    end
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'hC0DE;
    step();
    chk("br_ack", bus.dm_ack_o,   1);
    chk("br_rd",  bus.dm_rdata_o, 16'hC0DE);
    bus.dm_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();
    chk("br_ackpl", bus.dm_ack_o, 0);

    // reset in the middle of a fetch access
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 16'h0400;
    step();
    chk("r_busy", bus.mem_re_o, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("r_redrop", bus.mem_re_o,   0);
    chk("r_addr0",  bus.mem_addr_o, 0);
    chk("r_noack",  bus.if_ack_o,   0);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'h9999;
    step();
    chk("r_noack2", bus.if_ack_o, 0);
    bus.mem_ready_i = 1'b0;
    rst_n = 1'b1;
    step();
    chk("r_regrant", bus.mem_re_o,   1);
    chk("r_raddr",   bus.mem_addr_o, 16'h0400);
    bus.mem_ready_i = 1'b1;
    bus.mem_data_i  = 16'h0404;
    step();
    chk("r_ack", bus.if_ack_o,   1);
    chk("r_rd",  bus.if_rdata_o, 16'h0404);
    bus.if_req_i    = 1'b0;
    bus.mem_ready_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
